// File: rtl/fft_uart_tx.sv
// fft_uart_tx
// Serialises one FFT result frame onto an 8N1 UART line. On start it sends
// a 0xA5 header byte. It then fetches N samples one at a time through an
// en_out/in_valid handshake. Each sample is sent as sign-extended real
// bytes followed by sign-extended imaginary bytes, least significant byte
// first.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active high (1 = reset)
//   start      one-cycle frame start pulse (ignored unless idle)
//   in_valid   data_re/data_im valid (captured only while waiting)
//   data_re    signed real part, bit_width bits
//   data_im    signed imaginary part, bit_width bits
//   en_out     one-cycle request for the next sample
//   tx         UART line, idles high
//   busy       frame in progress
//   frame_done one-cycle pulse after the final stop bit
//
// States:
//   IDLE | waiting for start, line idle
//   HDR  | sending the 0xA5 header byte
//   REQ  | en_out asserted for one cycle
//   WAIT | waiting for in_valid to capture a sample
//   SEND | sending the captured sample bytes back to back
//   DONE | frame_done pulse, back to IDLE
module fft_uart_tx #(
    parameter int t_1_bit   = 5207,
    parameter int bit_width = 29,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [bit_width-1:0] data_re,
    input  logic [bit_width-1:0] data_im,
    output logic                 en_out,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BYTES  = (bit_width + 7) / 8;
    localparam int NB     = 2 * BYTES;
    localparam int CNT_W  = (t_1_bit > 1) ? $clog2(t_1_bit) : 1;
    localparam int BIDX_W = $clog2(NB);
    localparam int EXT    = 8 * BYTES - bit_width;
    localparam int REST_W = 8 * NB - 8;

    localparam logic [CNT_W-1:0]  T_LOAD    = CNT_W'(t_1_bit - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NB - 1);
    localparam logic [SIZE:0]     SMP_LAST  = (SIZE + 1)'(N - 1);
    localparam logic [7:0]        HDR_BYTE  = 8'hA5;

    typedef enum logic [2:0] {IDLE, HDR, REQ, WAIT, SEND, DONE} state_t;

    state_t              state, state_nxt;
    logic [9:0]          frame_sr;   // stop, data[7:0], start; bit 0 drives tx
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          bit_idx;
    logic [BIDX_W-1:0]   byte_idx;
    logic [SIZE:0]       smp_cnt;
    logic [REST_W-1:0]   rest_sr;    // sample bytes not yet loaded into frame_sr
    logic [8*BYTES-1:0]  re_ext, im_ext;
    logic [8*NB-1:0]     pair;
    logic                tx_active, bit_tick, byte_end, last_byte, last_smp;

    if (EXT > 0) begin : g_ext
        assign re_ext = {{EXT{data_re[bit_width-1]}}, data_re};
        assign im_ext = {{EXT{data_im[bit_width-1]}}, data_im};
    end else begin : g_noext
        assign re_ext = data_re;
        assign im_ext = data_im;
    end

    assign pair      = {im_ext, re_ext};
    assign tx_active = (state == HDR) || (state == SEND);
    assign bit_tick  = tx_active && (bit_cnt == '0);
    assign byte_end  = bit_tick && (bit_idx == 4'd9);
    assign last_byte = (byte_idx == BIDX_LAST);
    assign last_smp  = (smp_cnt == SMP_LAST);

    assign tx         = frame_sr[0];
    assign en_out     = (state == REQ);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = HDR;
            HDR:  if (byte_end) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: if (in_valid) state_nxt = SEND;
            SEND: if (byte_end && last_byte) state_nxt = last_smp ? DONE : REQ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            frame_sr <= '1;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            smp_cnt  <= '0;
            rest_sr  <= '0;
        end else begin
            // Bit timing: down-counter per bit, shift at terminal count.
            if (tx_active) begin
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - 1'b1;
                end else if (bit_idx != 4'd9) begin
                    bit_cnt  <= T_LOAD;
                    bit_idx  <= bit_idx + 1'b1;
                    frame_sr <= {1'b1, frame_sr[9:1]};
                end
            end
            // Byte loads override the shift; loading drives the start bit
            // on the following cycle so bytes run back to back.
            case (state)
                IDLE: if (start) begin
                    smp_cnt  <= '0;
                    frame_sr <= {1'b1, HDR_BYTE, 1'b0};
                    bit_cnt  <= T_LOAD;
                    bit_idx  <= '0;
                end
                HDR: if (byte_end) begin
                    frame_sr <= '1;
                    bit_idx  <= '0;
                end
                WAIT: if (in_valid) begin
                    rest_sr  <= pair[8*NB-1:8];
                    frame_sr <= {1'b1, pair[7:0], 1'b0};
                    bit_cnt  <= T_LOAD;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
                SEND: if (byte_end) begin
                    bit_idx <= '0;
                    if (last_byte) begin
                        frame_sr <= '1;
                        smp_cnt  <= smp_cnt + 1'b1;
                    end else begin
                        frame_sr <= {1'b1, rest_sr[7:0], 1'b0};
                        rest_sr  <= rest_sr >> 8;
                        bit_cnt  <= T_LOAD;
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_uart_tx.sv
module tb_fft_uart_tx;

    localparam int TB   = 4;   // cycles per bit
    localparam int BW   = 29;
    localparam int NS   = 2;
    localparam int NBY  = 8;   // bytes per sample
    localparam int BYT  = 10 * TB;

    typedef struct {
        logic [BW-1:0] re;
        logic [BW-1:0] im;
    } samp_t;

    logic          clk, rst_n, start, in_valid;
    logic [BW-1:0] data_re, data_im;
    logic          en_out, tx, busy, frame_done;

    fft_uart_tx #(.t_1_bit(TB), .bit_width(BW), .N(NS), .SIZE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .data_re(data_re), .data_im(data_im), .en_out(en_out), .tx(tx),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    samp_t samp_q[$];
    int    exp_q[$];
    int    rx_q[$];
    int    rx_st[$];
    int    glitch, frame_err, en_cnt, en_consec, first_en, fd_cnt, fd_cyc, stall_low;
    bit    stall_next, stray_next;
    int    cs;

    // UART receiver: one sample per cycle, 40 samples per byte.
    initial begin
        logic [39:0] smp;
        logic [7:0]  rb;
        int          pos;
        bit          on;
        on = 0;
        pos = 0;
        smp = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                on = 0;
            end else if (!on) begin
                if (tx === 1'b0) begin
                    on = 1;
                    smp[0] = tx;
                    pos = 1;
                    rx_st.push_back(cyc);
                end
            end else begin
                smp[pos] = tx;
                pos++;
                if (pos == BYT) begin
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < TB; j++)
                            if (smp[TB*b+j] !== smp[TB*b]) glitch++;
                    if (smp[0] !== 1'b0 || smp[9*TB] !== 1'b1) frame_err++;
                    for (int k = 0; k < 8; k++) rb[k] = smp[TB*(k+1)];
                    rx_q.push_back(int'(rb));
                    on = 0;
                end
            end
        end
    end

    // Handshake / frame_done monitor.
    initial begin
        bit prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (en_out === 1'b1) begin
                en_cnt++;
                if (prev) en_consec++;
                if (first_en < 0) first_en = cyc;
            end
            prev = (en_out === 1'b1);
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    // Sample responder for en_out requests.
    initial begin
        int    d;
        samp_t s;
        in_valid = 1'b0;
        data_re = '0;
        data_im = '0;
        forever begin
            @(posedge clk); #1;
            if (en_out === 1'b1 && rst_n === 1'b0) begin
                d = stall_next ? 50 : 1;
                stall_next = 0;
                repeat (d) begin
                    @(posedge clk); #1;
                    if (tx !== 1'b1) stall_low++;
                end
                if (samp_q.size() > 0) begin
                    s = samp_q.pop_front();
                    data_re = s.re;
                    data_im = s.im;
                end
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                data_re = 29'h1555_5555;
                data_im = 29'h0AAA_AAAA;
                if (stray_next) begin
                    stray_next = 0;
                    repeat (10) begin @(posedge clk); #1; end
                    data_re = 29'h0ABC_DEF1;
                    data_im = 29'h1234_5678;
                    in_valid = 1'b1;
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected bytes from the signed value: byte i of the sign-extended word.
    function automatic int byte_of(input logic [BW-1:0] v, input int i);
        int s;
        s = v[BW-1] ? (int'(v) - (1 << BW)) : int'(v);
        return (s >>> (8 * i)) & 255;
    endfunction

    task automatic add_sample(input logic [BW-1:0] re, input logic [BW-1:0] im);
        samp_t s;
        s.re = re;
        s.im = im;
        samp_q.push_back(s);
        for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(re, i));
        for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(im, i));
    endtask

    function automatic logic [BW-1:0] rnd();
        return BW'($urandom());
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rx_st.delete();
        exp_q.delete();
        samp_q.delete();
        exp_q.push_back(8'hA5);
        glitch = 0; frame_err = 0; en_cnt = 0; en_consec = 0;
        first_en = -1; fd_cnt = 0; fd_cyc = -1; stall_low = 0;
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        cs = cyc;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hdr_start_bit", {31'd0, tx}, 32'd0);
    endtask

    task automatic wait_done(input bit start_on_done);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        if (start_on_done) start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_frame();
        int last;
        chk("byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("byte[%0d]", i), rx_q[i], exp_q[i]);
        chk("bit_glitches", glitch, 0);
        chk("framing_errors", frame_err, 0);
        chk("en_out_consecutive", en_consec, 0);
        chk("fd_count", fd_cnt, 1);
        if (rx_st.size() == exp_q.size()) begin
            chk("hdr_start_cycle", rx_st[0], cs + 1);
            for (int s = 0; s < NS; s++)
                for (int j = 1; j < NBY; j++)
                    chk($sformatf("gap s%0d b%0d", s, j),
                        rx_st[1 + NBY*s + j] - rx_st[NBY*s + j], BYT);
            last = rx_st[rx_st.size() - 1];
            chk("frame_done_cycle", fd_cyc, last + BYT);
        end else begin
            chk("start_count", rx_st.size(), exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        stall_next = 0;
        stray_next = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_en_out", {31'd0, en_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        tick();

        // Frame A: directed values, incl. sign extension of 29'h1000_0000.
        clear_mon();
        add_sample(29'h0000_0005, 29'h1FFF_FFFF);
        add_sample(29'h1000_0000, rnd());
        start_frame();
        wait_done(0);
        check_frame();
        chk("A_en_count", en_cnt, NS);
        chk("A_first_en_cycle", first_en, cs + 1 + BYT);
        if (rx_st.size() > 1) chk("A_first_data_start", rx_st[1], cs + BYT + 3);
        if (rx_q.size() > 12) begin
            chk("A_re0_lsb", rx_q[1], 32'h05);
            chk("A_im0_msb", rx_q[8], 32'hFF);
            chk("A_sext_b0", rx_q[9], 32'h00);
            chk("A_sext_b3", rx_q[12], 32'hF0);
        end

        // Frame B: 50-cycle stall, stray in_valid, start while busy,
        // start coinciding with frame_done.
        clear_mon();
        add_sample(rnd(), rnd());
        add_sample(rnd(), rnd());
        stall_next = 1;
        stray_next = 1;
        start_frame();
        repeat (100) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1);
        check_frame();
        chk("B_en_count", en_cnt, NS);
        chk("B_stall_tx_low", stall_low, 0);
        if (rx_st.size() > 1) chk("B_first_data_start", rx_st[1], cs + BYT + 52);
        repeat (60) tick();
        chk("B_no_extra_bytes", rx_q.size(), 1 + NBY * NS);
        chk("B_idle_busy", {31'd0, busy}, 32'd0);
        chk("B_single_done", fd_cnt, 1);

        // Frame C: reset in the middle of a data byte.
        clear_mon();
        add_sample(rnd(), rnd());
        add_sample(rnd(), rnd());
        start_frame();
        repeat (150) tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("C_rst_tx", {31'd0, tx}, 32'd1);
        chk("C_rst_busy", {31'd0, busy}, 32'd0);
        chk("C_rst_en_out", {31'd0, en_out}, 32'd0);
        repeat (5) tick();

        // Frame D: full frame after the mid-frame reset.
        clear_mon();
        add_sample(rnd(), rnd());
        add_sample(rnd(), rnd());
        start_frame();
        wait_done(0);
        check_frame();
        chk("D_en_count", en_cnt, NS);
        if (rx_q.size() > 0) chk("D_header", rx_q[0], 32'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
